rx_queue_sched: RTL and testbench

Round-robin, credit-gated queue scheduler in front of `traffic_gen`. It tracks per-queue C2H descriptor credits and issues one packet grant at a time to the generator, together with the target `qid`. It stops after a programmed packet count or on command. Per-queue credit accounting lives here, so `traffic_gen` only sees "send one packet on queue N".

---
 rtl/rx_queue_sched_pkg.sv | 36 +++
 rtl/rx_queue_sched_if.sv | 30 +++
 rtl/rx_queue_sched_credit_bank.sv | 74 +++++++
 rtl/rx_queue_sched.sv | 190 +++++++++++++++++++
 tb/tb_rx_queue_sched.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_queue_sched_pkg.sv
// -----------------------------------------------------------------------------
// rx_queue_sched_pkg
// Shared types and helpers for the receive-queue scheduler:
//   - sched_state_t : scheduler FSM encoding (IDLE / SCAN / OFFER)
//   - DEF_QID_W, DEF_TM_DSC_BITS : default queue-id and credit widths
//   - sat_add()     : saturating credit add that also reports overflow
// -----------------------------------------------------------------------------
package rx_queue_sched_pkg;

    localparam int DEF_QID_W       = 11;
    localparam int DEF_TM_DSC_BITS = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_OFFER = 2'd2
    } sched_state_t;

    typedef logic [DEF_TM_DSC_BITS-1:0] credit_t;

    typedef struct packed {
        logic    ovf;
        credit_t sum;
    } sat_t;

    // Adds two credit values; on carry-out the sum pins to all-ones and ovf is set.
    function automatic sat_t sat_add(input credit_t a, input credit_t b);
        logic [DEF_TM_DSC_BITS:0] wide;
        sat_t                     r;
        wide  = {1'b0, a} + {1'b0, b};
        r.ovf = wide[DEF_TM_DSC_BITS];
        r.sum = r.ovf ? '1 : wide[DEF_TM_DSC_BITS-1:0];
        return r;
    endfunction

endpackage

// File: rtl/rx_queue_sched_if.sv
// -----------------------------------------------------------------------------
// rx_queue_sched_if
// Grant and credit-return signals of the scheduler.
//   pkt_valid / pkt_ready / pkt_qid      : one-packet grant to traffic_gen
//   credit_updt / credit_updt_qid / credit_in : descriptor credit returns
// master = scheduler side, slave = generator / credit source side.
// -----------------------------------------------------------------------------
interface rx_queue_sched_if
    import rx_queue_sched_pkg::*;
#(
    parameter int QID_W       = DEF_QID_W,
    parameter int TM_DSC_BITS = DEF_TM_DSC_BITS
);
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [QID_W-1:0]       pkt_qid;
    logic                   credit_updt;
    logic [QID_W-1:0]       credit_updt_qid;
    logic [TM_DSC_BITS-1:0] credit_in;

    modport master (
        output pkt_valid, pkt_qid,
        input  pkt_ready, credit_updt, credit_updt_qid, credit_in
    );

    modport slave (
        input  pkt_valid, pkt_qid,
        output pkt_ready, credit_updt, credit_updt_qid, credit_in
    );
endinterface

// File: rtl/rx_queue_sched_credit_bank.sv
// -----------------------------------------------------------------------------
// rx_queue_sched_credit_bank
// NUM_Q per-queue credit counters.
//   clk, rst_n            : clock, async active-low reset
//   clear                 : zero every counter (wins over add/subtract)
//   add_en/add_idx/add_val: saturating add on one counter
//   sub_en/sub_idx/sub_val: deduct on one counter (caller guarantees no underflow)
//   rd_idx / rd_data      : combinational read
//   ovf                   : the add in this cycle saturated
// -----------------------------------------------------------------------------
module rx_queue_sched_credit_bank
    import rx_queue_sched_pkg::*;
#(
    parameter  int NUM_Q       = 16,
    parameter  int TM_DSC_BITS = DEF_TM_DSC_BITS,
    localparam int IDX_W       = $clog2(NUM_Q)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   add_en,
    input  logic [IDX_W-1:0]       add_idx,
    input  logic [TM_DSC_BITS-1:0] add_val,
    input  logic                   sub_en,
    input  logic [IDX_W-1:0]       sub_idx,
    input  logic [TM_DSC_BITS-1:0] sub_val,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [TM_DSC_BITS-1:0] rd_data,
    output logic                   ovf
);

    logic [TM_DSC_BITS-1:0] credit     [NUM_Q];
    logic [TM_DSC_BITS-1:0] credit_nxt [NUM_Q];

    // The deduct is applied before the add so a same-queue add+deduct saturates
    // on credit + credit_in - perpkt rather than on the intermediate sum.
    always_comb begin
        logic [TM_DSC_BITS-1:0] base;
        sat_t                   r;
        // NOTE: every variable gets a default on entry so no path leaves it
        // holding a stale value, which would otherwise infer a latch.
        ovf  = 1'b0;
        base = '0;
        r    = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            // NOTE: combinational logic uses blocking '=' so later statements see
            // the updated value; clocked state below uses non-blocking '<='.
            base = credit[i];
            if (sub_en && sub_idx == IDX_W'(i))
                base = credit[i] - sub_val;
            credit_nxt[i] = base;
            if (add_en && add_idx == IDX_W'(i)) begin
                r             = sat_add(base, add_val);
                credit_nxt[i] = r.sum;
                ovf           = r.ovf;
            end
        end
    end

    // NOTE: this array is architectural state that must read zero after reset,
    // so it is reset explicitly instead of being left to power up undefined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_Q; i++) credit[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_Q; i++) credit[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_Q; i++) credit[i] <= credit_nxt[i];
        end
    end

    assign rd_data = credit[rd_idx];

endmodule

// File: rtl/rx_queue_sched.sv
// -----------------------------------------------------------------------------
// rx_queue_sched
// Round-robin, credit-gated queue scheduler in front of traffic_gen. Issues one
// "send a packet on qid N" grant at a time while the queue under the pointer
// has at least credit_perpkt credits.
//   axi_aclk, axi_aresetn : clock, async active-low reset
//   start / stop / clear  : control pulses
//   qid_base, num_queue, credit_perpkt, num_pkt : configuration (latched on start)
//   q_if (master)         : grant handshake and credit-update strobe
//   busy, done, pkt_sent  : status
//   err_bad_qid, err_ovf  : sticky error flags (cleared by clear)
// -----------------------------------------------------------------------------
module rx_queue_sched
    import rx_queue_sched_pkg::*;
#(
    parameter int NUM_Q       = 16,
    parameter int QID_W       = DEF_QID_W,
    parameter int TM_DSC_BITS = DEF_TM_DSC_BITS
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clear,
    input  logic [QID_W-1:0]       qid_base,
    input  logic [QID_W-1:0]       num_queue,
    input  logic [TM_DSC_BITS-1:0] credit_perpkt,
    input  logic [15:0]            num_pkt,
    rx_queue_sched_if.master       q_if,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pkt_sent,
    output logic                   err_bad_qid,
    output logic                   err_ovf
);

    localparam int              PTR_W  = $clog2(NUM_Q);
    localparam logic [PTR_W:0]  NQ_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]  NQ_MAX = (PTR_W+1)'(NUM_Q);

    sched_state_t           state, state_nxt;
    logic [PTR_W-1:0]       ptr;
    logic [QID_W-1:0]       base_r;
    logic [PTR_W:0]         nq_r;
    logic [TM_DSC_BITS-1:0] perpkt_r;
    logic [15:0]            num_pkt_r;
    logic                   stop_pend;
    logic                   pkt_valid_r;
    logic [QID_W-1:0]       pkt_qid_r;

    logic                   load, grant, accept, ptr_adv, last, ptr_wrap;
    logic [PTR_W:0]         nq_live;
    logic [TM_DSC_BITS-1:0] perpkt_live;
    logic [TM_DSC_BITS-1:0] credit_rd;
    logic                   bank_ovf;

    logic [QID_W-1:0]       updt_base, updt_off;
    logic [PTR_W:0]         updt_nq;
    logic                   updt_ok, add_en, bad_updt;

    // Configuration clamps: at least one queue, at most NUM_Q; at least one credit per packet.
    assign nq_live     = (num_queue == '0)            ? NQ_ONE :
                         (num_queue <  QID_W'(NUM_Q)) ? num_queue[PTR_W:0] : NQ_MAX;
    assign perpkt_live = (credit_perpkt == '0) ? TM_DSC_BITS'(1) : credit_perpkt;

    assign last     = (num_pkt_r != 16'd0) && (pkt_sent + 16'd1 == num_pkt_r);
    assign ptr_wrap = ({1'b0, ptr} == nq_r - NQ_ONE);

    // Credit returns are indexed relative to the latched window while running and
    // to the live configuration while idle; out-of-window updates are dropped.
    assign updt_base = busy ? base_r : qid_base;
    assign updt_nq   = busy ? nq_r   : nq_live;
    assign updt_off  = q_if.credit_updt_qid - updt_base;
    assign updt_ok   = updt_off < QID_W'(updt_nq);
    assign add_en    = q_if.credit_updt &&  updt_ok;
    assign bad_updt  = q_if.credit_updt && !updt_ok;

    rx_queue_sched_credit_bank #(
        .NUM_Q       (NUM_Q),
        .TM_DSC_BITS (TM_DSC_BITS)
    ) u_credit_bank (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .clear   (clear),
        .add_en  (add_en),
        .add_idx (updt_off[PTR_W-1:0]),
        .add_val (q_if.credit_in),
        .sub_en  (accept),
        .sub_idx (ptr),
        .sub_val (perpkt_r),
        .rd_idx  (ptr),
        .rd_data (credit_rd),
        .ovf     (bank_ovf)
    );

    // State register
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // Next-state logic. A stop seen during OFFER only takes effect on the accept.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_SCAN;
            S_SCAN: begin
                if (stop)                         state_nxt = S_IDLE;
                else if (credit_rd >= perpkt_r)   state_nxt = S_OFFER;
            end
            S_OFFER: begin
                if (q_if.pkt_ready)
                    state_nxt = (last || stop || stop_pend) ? S_IDLE : S_SCAN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control outputs driving the datapath registers below.
    always_comb begin
        load    = 1'b0;
        grant   = 1'b0;
        accept  = 1'b0;
        ptr_adv = 1'b0;
        unique case (state)
            S_IDLE: load = start;
            S_SCAN: begin
                if (!stop) begin
                    if (credit_rd >= perpkt_r) grant   = 1'b1;
                    else                       ptr_adv = 1'b1;
                end
            end
            S_OFFER: begin
                accept  = q_if.pkt_ready;
                ptr_adv = q_if.pkt_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            stop_pend   <= 1'b0;
            ptr         <= '0;
            base_r      <= '0;
            nq_r        <= NQ_ONE;
            perpkt_r    <= TM_DSC_BITS'(1);
            num_pkt_r   <= '0;
            pkt_sent    <= '0;
            pkt_valid_r <= 1'b0;
            pkt_qid_r   <= '0;
            err_bad_qid <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            done      <= accept && last;
            stop_pend <= (state == S_OFFER) && !accept && (stop || stop_pend);

            if (load) begin
                base_r    <= qid_base;
                nq_r      <= nq_live;
                perpkt_r  <= perpkt_live;
                num_pkt_r <= num_pkt;
                ptr       <= '0;
                pkt_sent  <= '0;
            end

            if (ptr_adv) ptr <= ptr_wrap ? '0 : ptr + PTR_W'(1);

            if (grant) begin
                pkt_valid_r <= 1'b1;
                pkt_qid_r   <= base_r + QID_W'(ptr);
            end

            if (accept) begin
                pkt_valid_r <= 1'b0;
                pkt_sent    <= pkt_sent + 16'd1;
            end

            err_bad_qid <= clear ? 1'b0 : (err_bad_qid | bad_updt);
            err_ovf     <= clear ? 1'b0 : (err_ovf | bank_ovf);
        end
    end

    assign q_if.pkt_valid = pkt_valid_r;
    assign q_if.pkt_qid   = pkt_qid_r;

endmodule

// File: tb/tb_rx_queue_sched.sv
// -----------------------------------------------------------------------------
// tb_rx_queue_sched
// Directed bench for rx_queue_sched: round-robin grants, credit gating, stalls,
// stop, same-cycle add/deduct, error flags, config clamps and async reset.
// -----------------------------------------------------------------------------
module tb_rx_queue_sched;

    localparam int NUM_Q       = 16;
    localparam int QID_W       = 11;
    localparam int TM_DSC_BITS = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start, stop, clear;
    logic [QID_W-1:0]       qid_base, num_queue;
    logic [TM_DSC_BITS-1:0] credit_perpkt;
    logic [15:0]            num_pkt;
    logic                   busy, done;
    logic [15:0]            pkt_sent;
    logic                   err_bad_qid, err_ovf;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    rx_queue_sched_if #(.QID_W(QID_W), .TM_DSC_BITS(TM_DSC_BITS)) q_if ();

    rx_queue_sched #(
        .NUM_Q       (NUM_Q),
        .QID_W       (QID_W),
        .TM_DSC_BITS (TM_DSC_BITS)
    ) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .start         (start),
        .stop          (stop),
        .clear         (clear),
        .qid_base      (qid_base),
        .num_queue     (num_queue),
        .credit_perpkt (credit_perpkt),
        .num_pkt       (num_pkt),
        .q_if          (q_if),
        .busy          (busy),
        .done          (done),
        .pkt_sent      (pkt_sent),
        .err_bad_qid   (err_bad_qid),
        .err_ovf       (err_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_credit(input int qid, input int val);
        q_if.credit_updt     = 1'b1;
        q_if.credit_updt_qid = QID_W'(qid);
        q_if.credit_in       = TM_DSC_BITS'(val);
        step();
        q_if.credit_updt     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Steps until pkt_valid is seen or the budget runs out; n = cycles waited.
    task automatic wait_valid(input string tag, input int budget, output int n);
        n = 0;
        while (!q_if.pkt_valid && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(q_if.pkt_valid), 32'd1);
    endtask

    function automatic logic [31:0] credit_of(input int i);
        return 32'(dut.u_credit_bank.credit[i]);
    endfunction

    initial begin
        int   n;
        logic seen;
        logic stable;

        rst_n                = 1'b1;
        start                = 1'b0;
        stop                 = 1'b0;
        clear                = 1'b0;
        qid_base             = '0;
        num_queue            = '0;
        credit_perpkt        = '0;
        num_pkt              = '0;
        q_if.pkt_ready       = 1'b0;
        q_if.credit_updt     = 1'b0;
        q_if.credit_updt_qid = '0;
        q_if.credit_in       = '0;

        // ---------------- reset state ----------------
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pkt_valid", 32'(q_if.pkt_valid), 32'd0);
        check("rst_busy",      32'(busy),           32'd0);
        check("rst_done",      32'(done),           32'd0);
        check("rst_pkt_sent",  32'(pkt_sent),       32'd0);
        check("rst_err_bad",   32'(err_bad_qid),    32'd0);
        check("rst_err_ovf",   32'(err_ovf),        32'd0);
        check("rst_credit0",   credit_of(0),        32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- 1: round robin over 4 queues, 8 packets ----------------
        qid_base       = 11'd0;
        num_queue      = 11'd4;
        credit_perpkt  = 16'd2;
        num_pkt        = 16'd8;
        q_if.pkt_ready = 1'b1;
        for (int q = 0; q < 4; q++) add_credit(q, 4);
        check("t1_credit3_loaded", credit_of(3), 32'd4);
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        for (int g = 0; g < 8; g++) begin
            wait_valid($sformatf("t1_valid%0d", g), 8, n);
            if (g == 0) check("t1_first_latency", 32'(n), 32'd1);
            if (g == 1) check("t1_peak_rate",     32'(n), 32'd1);
            check($sformatf("t1_qid%0d", g), 32'(q_if.pkt_qid), 32'(g % 4));
            step();
        end
        check("t1_done",      32'(done),           32'd1);
        check("t1_busy_low",  32'(busy),           32'd0);
        check("t1_pkt_sent",  32'(pkt_sent),       32'd8);
        check("t1_valid_low", 32'(q_if.pkt_valid), 32'd0);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);
        for (int q = 0; q < 4; q++)
            check($sformatf("t1_credit%0d_zero", q), credit_of(q), 32'd0);

        // ---------------- 2: credits only on qid 2, unlimited ----------------
        num_pkt = 16'd0;
        add_credit(2, 6);
        pulse_start();
        for (int g = 0; g < 3; g++) begin
            wait_valid($sformatf("t2_valid%0d", g), 8, n);
            check($sformatf("t2_qid%0d", g), 32'(q_if.pkt_qid), 32'd2);
            step();
        end
        seen = 1'b0;
        repeat (12) begin
            if (q_if.pkt_valid) seen = 1'b1;
            step();
        end
        check("t2_spin_no_valid", 32'(seen),     32'd0);
        check("t2_spin_busy",     32'(busy),     32'd1);
        check("t2_spin_sent",     32'(pkt_sent), 32'd3);
        add_credit(2, 2);
        wait_valid("t2_refill_valid", 5, n);
        check("t2_refill_qid", 32'(q_if.pkt_qid), 32'd2);

        // ---------------- 3: stall 10 cycles in OFFER, stop in window ----------------
        q_if.pkt_ready = 1'b0;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) stop = 1'b1;
            step();
            stop = 1'b0;
            if (!(q_if.pkt_valid === 1'b1 && q_if.pkt_qid === 11'd2)) stable = 1'b0;
        end
        check("t3_offer_stable", 32'(stable), 32'd1);
        check("t3_busy_held",    32'(busy),   32'd1);
        q_if.pkt_ready = 1'b1;
        step();
        check("t3_sent_after_accept", 32'(pkt_sent),       32'd4);
        check("t3_idle_after_stop",   32'(busy),           32'd0);
        check("t3_valid_dropped",     32'(q_if.pkt_valid), 32'd0);
        check("t3_no_done",           32'(done),           32'd0);
        repeat (6) step();
        check("t3_one_accept_only", 32'(pkt_sent), 32'd4);
        check("t3_credit2_zero",    credit_of(2),  32'd0);

        // ---------------- 4: same-cycle add and deduct on qid 1 ----------------
        add_credit(1, 3);
        num_pkt        = 16'd1;
        q_if.pkt_ready = 1'b0;
        pulse_start();
        check("t4_sent_reset", 32'(pkt_sent), 32'd0);
        wait_valid("t4_valid", 8, n);
        check("t4_qid", 32'(q_if.pkt_qid), 32'd1);
        q_if.pkt_ready       = 1'b1;
        q_if.credit_updt     = 1'b1;
        q_if.credit_updt_qid = 11'd1;
        q_if.credit_in       = 16'd5;
        step();
        q_if.credit_updt     = 1'b0;
        check("t4_credit1",   credit_of(1),  32'd6);
        check("t4_done",      32'(done),     32'd1);
        check("t4_pkt_sent",  32'(pkt_sent), 32'd1);

        // ---------------- 5: bad qid, overflow, clear ----------------
        add_credit(9, 7);
        check("t5_err_bad",       32'(err_bad_qid), 32'd1);
        check("t5_credit9_drop",  credit_of(9),     32'd0);
        check("t5_credit1_kept",  credit_of(1),     32'd6);
        check("t5_no_ovf_yet",    32'(err_ovf),     32'd0);
        add_credit(1, 16'hFFFF);
        check("t5_credit1_sat", credit_of(1),  32'h0000_FFFF);
        check("t5_err_ovf",     32'(err_ovf),  32'd1);
        pulse_clear();
        check("t5_clear_bad",    32'(err_bad_qid), 32'd0);
        check("t5_clear_ovf",    32'(err_ovf),     32'd0);
        check("t5_clear_credit", credit_of(1),     32'd0);
        check("t5_clear_sent",   32'(pkt_sent),    32'd1);

        // ---------------- 5b: clamps (num_queue 0 -> 1, perpkt 0 -> 1, >NUM_Q) ----------------
        qid_base      = 11'd100;
        num_queue     = 11'd0;
        credit_perpkt = 16'd0;
        num_pkt       = 16'd2;
        add_credit(101, 1);
        check("t5b_nq0_bad", 32'(err_bad_qid), 32'd1);
        add_credit(100, 2);
        check("t5b_credit0", credit_of(0), 32'd2);
        q_if.pkt_ready = 1'b1;
        pulse_start();
        for (int g = 0; g < 2; g++) begin
            wait_valid($sformatf("t5b_valid%0d", g), 8, n);
            check($sformatf("t5b_qid%0d", g), 32'(q_if.pkt_qid), 32'd100);
            step();
        end
        check("t5b_done",        32'(done),    32'd1);
        check("t5b_credit0_end", credit_of(0), 32'd0);
        pulse_clear();
        qid_base  = 11'd0;
        num_queue = 11'd40;
        add_credit(15, 1);
        check("t5b_nqmax_in",  credit_of(15),     32'd1);
        check("t5b_nqmax_ok",  32'(err_bad_qid),  32'd0);
        add_credit(16, 1);
        check("t5b_nqmax_out", 32'(err_bad_qid),  32'd1);
        pulse_clear();

        // ---------------- 6: asynchronous reset in OFFER ----------------
        num_queue     = 11'd4;
        credit_perpkt = 16'd2;
        num_pkt       = 16'd0;
        add_credit(0, 4);
        q_if.pkt_ready = 1'b1;
        pulse_start();
        wait_valid("t6_valid0", 8, n);
        step();
        q_if.pkt_ready = 1'b0;
        wait_valid("t6_valid1", 8, n);
        check("t6_qid",         32'(q_if.pkt_qid), 32'd0);
        check("t6_sent_before", 32'(pkt_sent),     32'd1);
        check("t6_credit_pre",  credit_of(0),      32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid",  32'(q_if.pkt_valid), 32'd0);
        check("t6_rst_busy",   32'(busy),           32'd0);
        check("t6_rst_sent",   32'(pkt_sent),       32'd0);
        check("t6_rst_credit", credit_of(0),        32'd0);
        #10 rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
